fd_queue: RTL and testbench
===========================

FD_QUEUE -- requirements
Module: fd_queue

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width; SHALL be at least 32.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 Parameter DEPTH, default 2, number of buffered fetch entries; SHALL be a power of two, at least 2.
REQ-004 Port clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port in_valid  in  1  fetch presents an instruction this cycle.
REQ-007 Port in_ready  out  1  queue accepts an instruction this cycle.
REQ-008 Port q_imem  in  DATA_W  fetched instruction word.
REQ-009 Port pc_in  in  PC_W  PC of the fetched instruction.
REQ-010 Port flush  in  1  discard all buffered entries (branch or jump redirect).
REQ-011 Port out_valid  out  1  head entry is valid for decode.
REQ-012 Port out_ready  in  1  decode consumes the head this cycle; low means stall.
REQ-013 Port inst_data  out  DATA_W  head instruction; all zeros (nop) when out_valid is 0.
REQ-014 Port pc_out  out  PC_W  head PC; all zeros when out_valid is 0.
REQ-015 Port opcode, rd, rs, rt_R, shamt_R, aluop_R  out  5 each  inst_data bit fields [31:27], [26:22], [21:17], [16:12], [11:7], [6:2].
REQ-016 Port immed_I  out  17  inst_data[16:0]; target_JI  out  27  inst_data[26:0].
REQ-017 Port count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-018 The block SHALL be a circular FIFO of DEPTH {instruction, PC} entries with a read pointer, a write pointer (log2(DEPTH) bits each, wrapping from DEPTH-1 to 0), and a count register.
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at the write pointer, and the write pointer increments.
REQ-020 Pop SHALL occur when out_valid && out_ready && !flush; the read pointer increments.
REQ-021 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL equal (count != 0); the head fields SHALL be driven from the entry at the read pointer.
REQ-023 Latency: a word pushed into an empty queue at edge N SHALL appear on inst_data with out_valid=1 after edge N; there is no combinational in-to-out path.
REQ-024 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 When full, the queue SHALL refuse a push even if a pop occurs in the same cycle.
REQ-026 When flush is high, both pointers and count SHALL become 0 at the next edge, and push and pop SHALL be suppressed that cycle; out_valid SHALL be 0 the following cycle.
REQ-027 Holding out_ready low SHALL keep the head fields stable for every stalled cycle.
REQ-028 Entry storage SHALL be written only on push; unused entries are don't-care but are never visible on the outputs.

Reset
REQ-029 Asserting reset (low) SHALL immediately clear pointers, count, and all entries to 0, independent of clock.
REQ-030 While in reset: out_valid=0, in_ready=1, inst_data=0, pc_out=0, count=0, and all decoded fields are 0.
REQ-031 Reset asserted mid-operation SHALL drop all buffered entries with no partial pop.

Configuration
REQ-032 Macro FD_PERF_EN, when defined, SHALL add output stall_cycles (32-bit): it increments each cycle out_valid && !out_ready, clears on reset, saturates at all-ones, and is unaffected by flush.
REQ-033 Without FD_PERF_EN, the port and the counter SHALL be absent, and the behaviour is otherwise identical.

Structure
REQ-034 Package fd_pkg SHALL hold the field position constants (OPC_HI/LO, RD_HI/LO, RS_HI/LO, RT_HI/LO, SHAMT_HI/LO, ALUOP_HI/LO, IMM_W=17, TGT_W=27) shared with the decode stage.
REQ-035 Pointer and count logic SHALL live in one sub-module, fd_fifo_ctrl (DEPTH parameter; push, pop, and flush in; pointers, count, full, and empty out).

Verification
REQ-036 Reset: drive reset low mid-run with 2 entries held -> out_valid=0, inst_data=0, count=0, and in_ready=1 immediately.
REQ-037 Fill: DEPTH=2 with out_ready=0; push 0x0A000001@PC 0x4 and 0x0A000002@PC 0x8 -> count=2, in_ready=0, head=0x0A000001; a third push is refused.
REQ-038 Stall and drain: after the fill, raise out_ready -> heads 0x0A000001 then 0x0A000002 on consecutive cycles, then out_valid=0 with inst_data=0.
REQ-039 Simultaneous: with count=1, push and pop in the same cycle -> count stays 1 and the new head is the pushed word; the write pointer wraps from 1 to 0 correctly.
REQ-040 Flush: with count=2, assert flush together with in_valid=1 -> next cycle count=0 and out_valid=0, and the flushed-cycle word is not stored.
REQ-041 Decode and perf: head 0xFFFFFFFF -> opcode=31, immed_I=0x1FFFF, target_JI=0x7FFFFFF; with FD_PERF_EN and 5 stalled valid cycles -> stall_cycles=5.

Source files
------------

// File: rtl/fd_pkg.sv
// fd_pkg: instruction field positions shared between the fetch/decode queue
// and the decode stage, plus the count-update encoding used by the queue control.
package fd_pkg;

  // Instruction field positions (bit indices within the instruction word)
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int SHAMT_HI = 11;
  localparam int SHAMT_LO = 7;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;
  localparam int FIELD_W  = 5;
  localparam int IMM_W    = 17;
  localparam int TGT_W    = 27;

  // How the occupancy count moves in a given cycle
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/fd_fifo_ctrl.sv
// fd_fifo_ctrl: read/write pointers and occupancy count for the fetch/decode
// circular queue. Push and pop arrive already handshaken; flush wins over both.
module fd_fifo_ctrl
  import fd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             push_s, pop_s, full_s, empty_s;
  cnt_op_e          cnt_op_s;

  // Status flags come straight from the count register
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == CNT_W'(0));
  end

  // Next pointers and count; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    push_s       = push && !flush && !full_s;
    pop_s        = pop && !flush && !empty_s;
    cnt_op_s     = CNT_HOLD;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    case ({push_s, pop_s})
      2'b10:   cnt_op_s = CNT_INC;
      2'b01:   cnt_op_s = CNT_DEC;
      default: cnt_op_s = CNT_HOLD;
    endcase
    if (flush) begin
      wr_ptr_nxt_s = PTR_W'(0);
      rd_ptr_nxt_s = PTR_W'(0);
      count_nxt_s  = CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case (cnt_op_s)
        CNT_INC: count_nxt_s = count_r + CNT_W'(1);
        CNT_DEC: count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and count registers, cleared immediately by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;
  assign full   = full_s;
  assign empty  = empty_s;

endmodule

// File: rtl/fd_queue.sv
// fd_queue: fetch-to-decode instruction queue. Buffers DEPTH {instruction, PC}
// pairs, presents the head with its decoded fields (zero when empty), and
// supports a redirect flush. Defining FD_PERF_EN adds a saturating 32-bit
// stall_cycles counter output.
module fd_queue
  import fd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         q_imem,
  input  logic [PC_W-1:0]           pc_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         inst_data,
  output logic [PC_W-1:0]           pc_out,
  output logic [FIELD_W-1:0]        opcode,
  output logic [FIELD_W-1:0]        rd,
  output logic [FIELD_W-1:0]        rs,
  output logic [FIELD_W-1:0]        rt_R,
  output logic [FIELD_W-1:0]        shamt_R,
  output logic [FIELD_W-1:0]        aluop_R,
  output logic [IMM_W-1:0]          immed_I,
  output logic [TGT_W-1:0]          target_JI,
`ifdef FD_PERF_EN
  output logic [31:0]               stall_cycles,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] inst_mem_r [DEPTH];
  logic [PC_W-1:0]   pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_s, rd_ptr_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s, empty_s;
  logic              push_s, pop_s;
  logic [DATA_W-1:0] head_inst_s;
  logic [PC_W-1:0]   head_pc_s;

  // Handshakes: ready/valid depend only on the registered count
  always_comb begin
    push_s = in_valid && !full_s && !flush;
    pop_s  = !empty_s && out_ready && !flush;
  end

  fd_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clock  (clock),
    .reset  (reset),
    .push   (push_s),
    .pop    (pop_s),
    .flush  (flush),
    .wr_ptr (wr_ptr_s),
    .rd_ptr (rd_ptr_s),
    .count  (count_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  // Entry storage: written only on an accepted push, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= DATA_W'(0);
        pc_mem_r[i]   <= PC_W'(0);
      end
    end else if (push_s) begin
      inst_mem_r[wr_ptr_s] <= q_imem;
      pc_mem_r[wr_ptr_s]   <= pc_in;
    end else begin
      inst_mem_r <= inst_mem_r;
      pc_mem_r   <= pc_mem_r;
    end
  end

  // Head presentation: nop and zero PC whenever nothing valid is buffered
  always_comb begin
    head_inst_s = DATA_W'(0);
    head_pc_s   = PC_W'(0);
    if (!empty_s) begin
      head_inst_s = inst_mem_r[rd_ptr_s];
      head_pc_s   = pc_mem_r[rd_ptr_s];
    end else begin
      head_inst_s = DATA_W'(0);
      head_pc_s   = PC_W'(0);
    end
  end

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign inst_data = head_inst_s;
  assign pc_out    = head_pc_s;
  assign count     = count_s;

  assign opcode    = head_inst_s[OPC_HI:OPC_LO];
  assign rd        = head_inst_s[RD_HI:RD_LO];
  assign rs        = head_inst_s[RS_HI:RS_LO];
  assign rt_R      = head_inst_s[RT_HI:RT_LO];
  assign shamt_R   = head_inst_s[SHAMT_HI:SHAMT_LO];
  assign aluop_R   = head_inst_s[ALUOP_HI:ALUOP_LO];
  assign immed_I   = head_inst_s[IMM_W-1:0];
  assign target_JI = head_inst_s[TGT_W-1:0];

`ifdef FD_PERF_EN
  logic [31:0] stall_cycles_r;

  // Count cycles where decode holds back a valid head; saturates, ignores flush
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= 32'd0;
    end else if (!empty_s && !out_ready && (stall_cycles_r != {32{1'b1}})) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_fd_queue.sv
// tb_fd_queue: directed, table-driven bench for fd_queue (DEPTH=2), with
// hand-written sequences for asynchronous reset, decode fields and stalls.
module tb_fd_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] q_imem;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_data;
  logic [31:0] pc_out;
  logic [4:0]  opcode, rd, rs, rt_R, shamt_R, aluop_R;
  logic [16:0] immed_I;
  logic [26:0] target_JI;
  logic [1:0]  count;
`ifdef FD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fd_queue #(.DATA_W(32), .PC_W(32), .DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_imem    (q_imem),
    .pc_in     (pc_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst_data (inst_data),
    .pc_out    (pc_out),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .rt_R      (rt_R),
    .shamt_R   (shamt_R),
    .aluop_R   (aluop_R),
    .immed_I   (immed_I),
    .target_JI (target_JI),
`ifdef FD_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    q_imem    = d;
    pc_in     = pc;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    //            iv    data          pc     fl    ordy  ov    ir    inst          pc     cnt
    vecs[0]  = '{1'b1, 32'h0A000001, 32'h04, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0A000001, 32'h04, 2'd1};
    vecs[1]  = '{1'b1, 32'h0A000002, 32'h08, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0A000001, 32'h04, 2'd2};
    vecs[2]  = '{1'b1, 32'h0A000003, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0A000001, 32'h04, 2'd2};
    vecs[3]  = '{1'b0, 32'h00000000, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0A000002, 32'h08, 2'd1};
    vecs[4]  = '{1'b0, 32'h00000000, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00, 2'd0};
    vecs[5]  = '{1'b1, 32'h0B000001, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0B000001, 32'h10, 2'd1};
    vecs[6]  = '{1'b1, 32'h0B000002, 32'h14, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0B000002, 32'h14, 2'd1};
    vecs[7]  = '{1'b1, 32'h0B000003, 32'h18, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0B000002, 32'h14, 2'd2};
    vecs[8]  = '{1'b1, 32'h0D000001, 32'h30, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0B000003, 32'h18, 2'd1};
    vecs[9]  = '{1'b1, 32'h0D000002, 32'h34, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0B000003, 32'h18, 2'd2};
    vecs[10] = '{1'b1, 32'h0C000001, 32'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00, 2'd0};
    vecs[11] = '{1'b0, 32'h00000000, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00, 2'd0};
    vecs[12] = '{1'b1, 32'hFFFFFFFF, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h20, 2'd1};

    // Power-on reset state
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_inst",      64'(inst_data), 64'd0);
    #12 reset = 1'b1;
    step();

    // Table-driven main sequence
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].pc, vecs[i].fl, vecs[i].ordy);
      step();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
      chk($sformatf("v%0d_inst", i),      64'(inst_data), 64'(vecs[i].e_inst));
      chk($sformatf("v%0d_pc", i),        64'(pc_out),    64'(vecs[i].e_pc));
      chk($sformatf("v%0d_count", i),     64'(count),     64'(vecs[i].e_cnt));
      if (i == 0) begin
        chk("dec_a1_opcode", 64'(opcode), 64'd1);
        chk("dec_a1_rd",     64'(rd),     64'd8);
      end
    end

    // All-ones head decode
    chk("dec_ff_opcode", 64'(opcode),    64'd31);
    chk("dec_ff_rd",     64'(rd),        64'd31);
    chk("dec_ff_aluop",  64'(aluop_R),   64'd31);
    chk("dec_ff_imm",    64'(immed_I),   64'h1FFFF);
    chk("dec_ff_tgt",    64'(target_JI), 64'h7FFFFFF);

    // Reset mid-run with two entries held
    drive(1'b1, 32'h0E000001, 32'h24, 1'b0, 1'b0);
    step();
    chk("pre_rst_count", 64'(count), 64'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst_count",     64'(count),     64'd0);
    chk("mid_rst_inst",      64'(inst_data), 64'd0);
    chk("mid_rst_pc",        64'(pc_out),    64'd0);
    chk("mid_rst_opcode",    64'(opcode),    64'd0);
    chk("mid_rst_imm",       64'(immed_I),   64'd0);
    #10;
    chk("held_rst_count",    64'(count),     64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Stall with a valid head: head stable, fields decoded
    drive(1'b1, 32'h12345678, 32'h40, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d_inst", k),  64'(inst_data), 64'h12345678);
      chk($sformatf("stall%0d_pc", k),    64'(pc_out),    64'h40);
      chk($sformatf("stall%0d_count", k), 64'(count),     64'd1);
    end
    chk("dec_opcode", 64'(opcode),    64'd2);
    chk("dec_rd",     64'(rd),        64'd8);
    chk("dec_rs",     64'(rs),        64'd26);
    chk("dec_rt",     64'(rt_R),      64'd5);
    chk("dec_shamt",  64'(shamt_R),   64'd12);
    chk("dec_aluop",  64'(aluop_R),   64'd30);
    chk("dec_imm",    64'(immed_I),   64'h05678);
    chk("dec_tgt",    64'(target_JI), 64'h2345678);
`ifdef FD_PERF_EN
    chk("stall_cycles_5", 64'(stall_cycles), 64'd5);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_inst",      64'(inst_data), 64'd0);
`ifdef FD_PERF_EN
    chk("stall_cycles_hold", 64'(stall_cycles), 64'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
